// File: rtl/lru_pkg.sv
// Shared constants, FSM state encoding and a one-hot to binary helper for
// the LRU access controller.
package lru_pkg;

  localparam int LRU_WAYS   = 8;
  localparam int LRU_SETS   = 128;
  localparam int LRU_ADDR_W = 7;
  localparam int LRU_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    RESP   = 2'd2
  } lru_state_e;

  // Binary index of a one-hot vector; an all-zero vector maps to index 0.
  function automatic logic [LRU_IDX_W-1:0] onehot_to_idx(input logic [LRU_WAYS-1:0] oh);
    logic [LRU_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LRU_WAYS; i++) begin
      if (oh[i]) idx = idx | LRU_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_access_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder over a way vector (module lru_prio_enc).
// Produces the isolated lowest bit as one-hot, its binary index, and a flag
// when no bit is set.
module lru_prio_enc
  import lru_pkg::*;
(
  input  logic [LRU_WAYS-1:0]  i_vec,
  output logic [LRU_WAYS-1:0]  o_onehot,
  output logic [LRU_IDX_W-1:0] o_idx,
  output logic                 o_none
);

  // w_lower[k] is set when any bit below position k is set.
  logic [LRU_WAYS:0] w_lower;

  assign w_lower[0] = 1'b0;

  for (genvar gi = 0; gi < LRU_WAYS; gi++) begin : g_bit
    assign w_lower[gi+1] = w_lower[gi] | i_vec[gi];
    assign o_onehot[gi]  = i_vec[gi] & ~w_lower[gi];
  end

  assign o_idx  = onehot_to_idx(o_onehot);
  assign o_none = ~w_lower[LRU_WAYS];

endmodule

// File: rtl/lru_access_ctrl.sv
// Initiator side of the 8-way LRU age-buffer interface. Takes one lookup at
// a time, issues a single LRU write (hit touch or miss replacement) and
// returns the hit/victim way to the cache pipeline.
// Optional macro LRU_ERR_CHECK_EN enables the sticky protocol error flag o_err.
module lru_access_ctrl
  import lru_pkg::*;
#(
  parameter int WAYS   = LRU_WAYS,
  parameter int ADDR_W = LRU_ADDR_W,
  parameter int IDX_W  = LRU_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [WAYS-1:0]   i_req_hit_way,
  output logic [ADDR_W-1:0] o_lru_addr,
  output logic [WAYS-1:0]   o_lru_hit_way,
  output logic              o_lru_hit_sig,
  output logic              o_lru_we,
  input  logic [WAYS-1:0]   i_lru_flag,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic              o_resp_hit,
  output logic [WAYS-1:0]   o_resp_way,
  output logic [IDX_W-1:0]  o_resp_idx,
  output logic              o_err
);

  lru_state_e r_state, r_state_next;

  logic [ADDR_W-1:0] r_req_addr;
  logic [WAYS-1:0]   r_hit_way;
  logic [IDX_W-1:0]  r_hit_idx;
  logic              r_resp_hit;
  logic [WAYS-1:0]   r_resp_way;
  logic [IDX_W-1:0]  r_resp_idx;

  logic [WAYS-1:0]   w_in_oh;
  logic [IDX_W-1:0]  w_in_idx;
  logic              w_in_none;
  logic [WAYS-1:0]   w_vic_oh;
  logic [IDX_W-1:0]  w_vic_idx;
  logic              w_vic_none;
  logic [WAYS-1:0]   w_victim;
  logic              w_hit;
  logic              w_accept;

  // Normalise the tag-compare vector at accept: a multi-hot vector keeps only its lowest way.
  lru_prio_enc u_hit_enc (
    .i_vec    (i_req_hit_way),
    .o_onehot (w_in_oh),
    .o_idx    (w_in_idx),
    .o_none   (w_in_none)
  );

  // Victim is the lowest set bit of the buffer's LRU flag.
  lru_prio_enc u_vic_enc (
    .i_vec    (i_lru_flag),
    .o_onehot (w_vic_oh),
    .o_idx    (w_vic_idx),
    .o_none   (w_vic_none)
  );

  // An empty LRU flag still needs a definite victim, so fall back to way 0.
  assign w_victim      = w_vic_none ? WAYS'(1) : w_vic_oh;
  assign w_hit         = |r_hit_way;
  assign o_lru_hit_sig = w_hit;
  assign o_lru_hit_way = w_hit ? r_hit_way : w_victim;
  assign o_lru_addr    = r_req_addr;
  assign o_resp_hit    = r_resp_hit;
  assign o_resp_way    = r_resp_way;
  assign o_resp_idx    = r_resp_idx;
  assign w_accept      = o_req_ready & i_req_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= r_state_next;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    r_state_next = r_state;
    o_req_ready  = 1'b0;
    o_lru_we     = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) r_state_next = UPDATE;
      end
      UPDATE: begin
        o_lru_we     = 1'b1;
        r_state_next = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) r_state_next = IDLE;
      end
      default: r_state_next = IDLE;
    endcase
  end

  // Request capture at accept, response capture during the single UPDATE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_addr <= '0;
      r_hit_way  <= '0;
      r_hit_idx  <= '0;
      r_resp_hit <= 1'b0;
      r_resp_way <= '0;
      r_resp_idx <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr <= i_req_addr;
        r_hit_way  <= w_in_none ? '0 : w_in_oh;
        r_hit_idx  <= w_in_idx;
      end
      if (r_state == UPDATE) begin
        r_resp_hit <= w_hit;
        r_resp_way <= o_lru_hit_way;
        r_resp_idx <= w_hit ? r_hit_idx : w_vic_idx;
      end
    end
  end

`ifdef LRU_ERR_CHECK_EN
  logic r_err;

  // Sticky error: multi-hot hit vector at accept, or a non-one-hot LRU flag on a miss update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((w_accept && (i_req_hit_way != w_in_oh)) ||
                 ((r_state == UPDATE) && !w_hit && (w_vic_none || (i_lru_flag != w_vic_oh)))) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_lru_access_ctrl.sv
// Directed self-checking bench for lru_access_ctrl, with a small age-based
// LRU buffer model used for the back-to-back miss sequence.
module tb_lru_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       o_req_ready;
  logic [6:0] i_req_addr = '0;
  logic [7:0] i_req_hit_way = '0;
  logic [6:0] o_lru_addr;
  logic [7:0] o_lru_hit_way;
  logic       o_lru_hit_sig;
  logic       o_lru_we;
  logic [7:0] i_lru_flag;
  logic       o_resp_valid;
  logic       i_resp_ready = 1'b1;
  logic       o_resp_hit;
  logic [7:0] o_resp_way;
  logic [2:0] o_resp_idx;
  logic       o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int we_snap;

  logic       use_model = 1'b0;
  logic [7:0] flag_ovr  = 8'h80;
  logic [7:0] model_flag;
  logic [2:0] age [128][8];

  always #5 clk = ~clk;

  lru_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_hit_way (i_req_hit_way),
    .o_lru_addr    (o_lru_addr),
    .o_lru_hit_way (o_lru_hit_way),
    .o_lru_hit_sig (o_lru_hit_sig),
    .o_lru_we      (o_lru_we),
    .i_lru_flag    (i_lru_flag),
    .o_resp_valid  (o_resp_valid),
    .i_resp_ready  (i_resp_ready),
    .o_resp_hit    (o_resp_hit),
    .o_resp_way    (o_resp_way),
    .o_resp_idx    (o_resp_idx),
    .o_err         (o_err)
  );

  // LRU buffer model: age 7 is least recently used; way 0 starts oldest.
  always @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 128; s++)
        for (int w = 0; w < 8; w++) age[s][w] <= 3'(7 - w);
    end else if (o_lru_we) begin
      for (int k = 0; k < 8; k++) begin
        if (o_lru_hit_way[k]) begin
          for (int w = 0; w < 8; w++)
            if (age[o_lru_addr][w] < age[o_lru_addr][k]) age[o_lru_addr][w] <= age[o_lru_addr][w] + 3'd1;
          age[o_lru_addr][k] <= 3'd0;
        end
      end
    end
  end

  always_comb begin
    model_flag = '0;
    for (int w = 0; w < 8; w++)
      if (age[o_lru_addr][w] == 3'd7) model_flag[w] = 1'b1;
  end

  assign i_lru_flag = use_model ? model_flag : flag_ovr;

  always @(posedge clk) if (o_lru_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one request at a negedge; returns #1 after the accept edge (UPDATE cycle).
  task automatic send(input logic [6:0] a, input logic [7:0] h);
    @(negedge clk);
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid   = 1'b1;
    i_req_addr    = a;
    i_req_hit_way = h;
    @(posedge clk);
    #1;
    i_req_valid   = 1'b0;
    $display("req addr=%02h hit_way=%02h lru_we=%0d lru_hit_way=%02h", a, h, o_lru_we, o_lru_hit_way);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_lru_we", 32'(o_lru_we), 32'd0);
    chk("rst_lru_addr", 32'(o_lru_addr), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Hit
    send(7'h15, 8'b0000_0100);
    chk("hit_we", 32'(o_lru_we), 32'd1);
    chk("hit_sig", 32'(o_lru_hit_sig), 32'd1);
    chk("hit_way", 32'(o_lru_hit_way), 32'h04);
    chk("hit_addr", 32'(o_lru_addr), 32'h15);
    chk("hit_upd_ready", 32'(o_req_ready), 32'd0);
    step();
    chk("hit_resp_valid", 32'(o_resp_valid), 32'd1);
    chk("hit_resp_hit", 32'(o_resp_hit), 32'd1);
    chk("hit_resp_way", 32'(o_resp_way), 32'h04);
    chk("hit_resp_idx", 32'(o_resp_idx), 32'd2);
    chk("hit_resp_we", 32'(o_lru_we), 32'd0);
    step();
    chk("hit_back_idle", 32'(o_req_ready), 32'd1);
    chk("hit_resp_drop", 32'(o_resp_valid), 32'd0);
    chk("hit_addr_hold", 32'(o_lru_addr), 32'h15);

    // Miss with buffer flag driven to way 5
    flag_ovr = 8'b0010_0000;
    send(7'h03, 8'h00);
    chk("miss_sig", 32'(o_lru_hit_sig), 32'd0);
    chk("miss_way", 32'(o_lru_hit_way), 32'h20);
    step();
    chk("miss_resp_hit", 32'(o_resp_hit), 32'd0);
    chk("miss_resp_way", 32'(o_resp_way), 32'h20);
    chk("miss_resp_idx", 32'(o_resp_idx), 32'd5);
    step();

    // Backpressure
    i_resp_ready = 1'b0;
    we_snap = we_cnt;
    send(7'h40, 8'h80);
    for (int c = 0; c < 5; c++) begin
      step();
      i_req_valid = 1'b1;
      chk("bp_valid", 32'(o_resp_valid), 32'd1);
      chk("bp_way", 32'(o_resp_way), 32'h80);
      chk("bp_idx", 32'(o_resp_idx), 32'd7);
      chk("bp_ready", 32'(o_req_ready), 32'd0);
      chk("bp_we", 32'(o_lru_we), 32'd0);
    end
    i_req_valid = 1'b0;
    i_resp_ready = 1'b1;
    step();
    chk("bp_release", 32'(o_resp_valid), 32'd0);
    chk("bp_we_once", 32'(we_cnt - we_snap), 32'd1);

    // Back-to-back misses to set 0 against the buffer model
    use_model = 1'b1;
    for (int v = 0; v < 3; v++) begin
      send(7'h00, 8'h00);
      chk("b2b_upd_way", 32'(o_lru_hit_way), 32'(8'h01 << v));
      step();
      chk("b2b_resp_way", 32'(o_resp_way), 32'(8'h01 << v));
      chk("b2b_resp_idx", 32'(o_resp_idx), 32'(v));
      $display("b2b miss %0d victim=%02h idx=%0d", v, o_resp_way, o_resp_idx);
      step();
    end
    use_model = 1'b0;

    // Reset in the middle of RESP
    i_resp_ready = 1'b0;
    send(7'h11, 8'h02);
    step();
    chk("mid_rst_valid_before", 32'(o_resp_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid_async", 32'(o_resp_valid), 32'd0);
    chk("mid_rst_ready_async", 32'(o_req_ready), 32'd1);
    chk("mid_rst_way", 32'(o_resp_way), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    i_resp_ready = 1'b1;
    we_snap = we_cnt;
    repeat (4) step();
    chk("post_rst_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("post_rst_idle", 32'(o_req_ready), 32'd1);

    // Multi-hot hit vector: lowest way is forwarded
    send(7'h22, 8'b0001_0010);
    chk("mh_sig", 32'(o_lru_hit_sig), 32'd1);
    chk("mh_lru_way", 32'(o_lru_hit_way), 32'h02);
    step();
    chk("mh_resp_way", 32'(o_resp_way), 32'h02);
    chk("mh_resp_idx", 32'(o_resp_idx), 32'd1);
`ifdef LRU_ERR_CHECK_EN
    chk("mh_err", 32'(o_err), 32'd1);
`else
    chk("mh_err", 32'(o_err), 32'd0);
`endif
    step();
    send(7'h23, 8'h08);
    step();
    step();
`ifdef LRU_ERR_CHECK_EN
    chk("mh_err_sticky", 32'(o_err), 32'd1);
`else
    chk("mh_err_sticky", 32'(o_err), 32'd0);
`endif

    // Empty LRU flag on a miss: victim falls back to way 0
    rst_pulse();
    chk("zf_err_clear", 32'(o_err), 32'd0);
    flag_ovr = 8'h00;
    send(7'h30, 8'h00);
    chk("zf_lru_way", 32'(o_lru_hit_way), 32'h01);
    step();
    chk("zf_resp_way", 32'(o_resp_way), 32'h01);
    chk("zf_resp_idx", 32'(o_resp_idx), 32'd0);
`ifdef LRU_ERR_CHECK_EN
    chk("zf_err", 32'(o_err), 32'd1);
`else
    chk("zf_err", 32'(o_err), 32'd0);
`endif
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
